// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: owns the architectural PC, pulls one instruction a byte at a
// time over a req/ack memory port and presents the decoded fields under valid/ready.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [63:0] MAX_ADDR = 64'hFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DONE    = 3'd2,
        S_WAIT_PC = 3'd3,
        S_STOP    = 3'd4
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic [3:0]  r_k;
    logic [3:0]  r_icode;
    logic [3:0]  r_ifun;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic [2:0]  r_stat;
    logic        r_out_valid;

    logic [64:0] w_addr_sum;
    logic        w_addr_bad;
    logic [3:0]  w_icode_now;
    logic [3:0]  w_len;
    logic        w_last;
    logic        w_has_regs;
    logic [2:0]  w_vidx;
    logic        w_byte_ok;
    logic        w_complete;
    logic        w_retire;
    logic        w_fail_adr;
    logic        w_fail_ins;

    function automatic logic [3:0] insn_len(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       insn_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: insn_len = 4'd2;
            4'h7, 4'h8:             insn_len = 4'd9;
            4'h3, 4'h4, 4'h5:       insn_len = 4'd10;
            default:                insn_len = 4'd1;
        endcase
    endfunction

    // 65-bit sum so a wrap past 2^64 is seen as out of range rather than a low address.
    assign w_addr_sum  = {1'b0, r_pc} + {61'd0, r_k};
    assign w_addr_bad  = w_addr_sum[64] | (w_addr_sum[63:0] > MAX_ADDR);
    assign w_icode_now = (r_k == 4'd0) ? imem_rdata[7:4] : r_icode;
    assign w_len       = insn_len(w_icode_now);
    assign w_last      = ((r_k + 4'd1) == w_len);
    assign w_has_regs  = (r_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    // valC byte slot: constant starts after the register byte when there is one.
    assign w_vidx      = w_has_regs ? 3'(r_k - 4'd2) : 3'(r_k - 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_byte_ok   = 1'b0;
        w_complete  = 1'b0;
        w_retire    = 1'b0;
        w_fail_adr  = 1'b0;
        w_fail_ins  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_addr_bad) begin
                    w_fail_adr  = 1'b1;
                    w_state_nxt = S_STOP;
                end else if (imem_ack) begin
                    if (imem_err) begin
                        w_fail_adr  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else if ((r_k == 4'd0) && (imem_rdata[7:4] > 4'hB)) begin
                        w_fail_ins  = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_byte_ok = 1'b1;
                        if (w_last) begin
                            w_complete  = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_retire    = 1'b1;
                    w_state_nxt = (r_icode == 4'h0) ? S_STOP : S_WAIT_PC;
                end
            end
            default: ;
        endcase
        // A PC load overrides everything, including an acked byte or a DONE handshake.
        if (pc_load) begin
            w_state_nxt = S_IDLE;
            w_byte_ok   = 1'b0;
            w_complete  = 1'b0;
            w_retire    = 1'b0;
            w_fail_adr  = 1'b0;
            w_fail_ins  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_k         <= 4'd0;
            r_out_valid <= 1'b0;
            r_stat      <= STAT_AOK;
            r_icode     <= 4'h0;
            r_ifun      <= 4'h0;
            r_ra        <= 4'hF;
            r_rb        <= 4'hF;
            r_valc      <= 64'd0;
            r_valp      <= 64'd0;
        end else if (pc_load) begin
            r_pc        <= pc_in;
            r_k         <= 4'd0;
            r_out_valid <= 1'b0;
            r_stat      <= STAT_AOK;
        end else begin
            if ((r_state == S_IDLE) && en) r_k <= 4'd0;
            if (w_fail_adr) r_stat <= STAT_ADR;
            if (w_fail_ins) r_stat <= STAT_INS;
            if (w_byte_ok) begin
                r_k <= r_k + 4'd1;
                if (r_k == 4'd0) begin
                    r_icode <= imem_rdata[7:4];
                    r_ifun  <= imem_rdata[3:0];
                    r_ra    <= 4'hF;
                    r_rb    <= 4'hF;
                    r_valc  <= 64'd0;
                end else if ((r_k == 4'd1) && w_has_regs) begin
                    r_ra <= imem_rdata[7:4];
                    r_rb <= imem_rdata[3:0];
                end else begin
                    r_valc[{w_vidx, 3'b000} +: 8] <= imem_rdata;
                end
            end
            if (w_complete) begin
                r_out_valid <= 1'b1;
                r_stat      <= STAT_AOK;
                r_valp      <= r_pc + {60'd0, w_len};
            end
            if (w_retire) begin
                r_out_valid <= 1'b0;
                if (r_icode == 4'h0) r_stat <= STAT_HLT;
            end
        end
    end

    // Request is decoded from registered state only, so reset drops it asynchronously.
    assign imem_req  = (r_state == S_FETCH) & ~w_addr_bad;
    assign imem_addr = w_addr_sum[63:0];
    assign out_valid = r_out_valid;
    assign icode     = r_icode;
    assign ifun      = r_ifun;
    assign rA        = r_ra;
    assign rB        = r_rb;
    assign valC      = r_valc;
    assign valP      = r_valp;
    assign pc        = r_pc;
    assign stat      = r_stat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized fetches
// compared against a byte-level reference decoder and an address scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
    int          nbytes;
    bit          addr_fault;
  } ref_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        en = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_in = 64'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [7:0]  imem_rdata = 8'd0;
  logic        imem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp, pc;
  logic [2:0]  stat, dbg_state;

  // ---------------- small-window DUT signals ----------------
  logic        s_en = 1'b0;
  logic        s_pc_load = 1'b0;
  logic [63:0] s_pc_in = 64'd0;
  logic        s_req;
  logic [63:0] s_addr;
  logic        s_ack;
  logic [7:0]  s_rdata;
  logic        s_err = 1'b0;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [3:0]  s_icode, s_ifun, s_ra, s_rb;
  logic [63:0] s_valc, s_valp, s_pc;
  logic [2:0]  s_stat, s_state;
  logic [63:0] s_max_seen = 64'd0;

  logic [7:0] mem [0:8191];
  logic       err_mem [0:8191];

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc_load(pc_load), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(ra), .rB(rb), .valC(valc), .valP(valp),
    .pc(pc), .stat(stat), .dbg_state(dbg_state)
  );

  fetch_unit #(.RESET_PC(64'h0), .MAX_ADDR(64'h9)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .pc_load(s_pc_load), .pc_in(s_pc_in),
    .imem_req(s_req), .imem_addr(s_addr), .imem_ack(s_ack),
    .imem_rdata(s_rdata), .imem_err(s_err),
    .out_valid(s_valid), .out_ready(s_ready),
    .icode(s_icode), .ifun(s_ifun), .rA(s_ra), .rB(s_rb), .valC(s_valc), .valP(s_valp),
    .pc(s_pc), .stat(s_stat), .dbg_state(s_state)
  );

  assign s_ack   = s_req;
  assign s_rdata = mem[s_addr[12:0]];
  always @(negedge clk) if (s_req && (s_addr > s_max_seen)) s_max_seen = s_addr;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder + address scoreboard ----------------
  int          mem_wait = 0;
  int          wcnt = 0;
  int          ack_cnt = 0;
  int          req_seen = 0;
  bit          sb_on = 1'b0;
  bit          prev_wait = 1'b0;
  logic [63:0] held_addr = 64'd0;
  logic [63:0] exp_addr;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (imem_req) begin
      req_seen++;
      if (prev_wait) check("addr_stable", imem_addr, held_addr);
      if (wcnt >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[imem_addr[12:0]];
        imem_err   = err_mem[imem_addr[12:0]];
        wcnt       = 0;
        prev_wait  = 1'b0;
        ack_cnt++;
        if (sb_on) begin
          if (exp_q.size() > 0) exp_addr = exp_q.pop_front();
          else                  exp_addr = 64'hDEAD_BEEF_DEAD_BEEF;
          check("req_addr", imem_addr, exp_addr);
        end
      end else begin
        imem_ack  = 1'b0;
        imem_err  = 1'b0;
        wcnt++;
        prev_wait = 1'b1;
        held_addr = imem_addr;
      end
    end else begin
      imem_ack  = 1'b0;
      imem_err  = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int len_of_icode(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 0;
    endcase
  endfunction

  function automatic ref_t model(input logic [63:0] start, input logic [63:0] maxa);
    ref_t r;
    logic [7:0]  b [0:9];
    logic [64:0] a;
    int len;
    r.icode = 4'h0; r.ifun = 4'h0; r.ra = 4'hF; r.rb = 4'hF;
    r.valc = 64'd0; r.valp = 64'd0; r.stat = 3'd1; r.nbytes = 0; r.addr_fault = 1'b0;
    len = 10;
    for (int i = 0; i < len; i++) begin
      a = {1'b0, start} + 65'(i);
      if (a > {1'b0, maxa}) begin
        r.stat = 3'd3; r.addr_fault = 1'b1; r.nbytes = i;
        return r;
      end
      r.nbytes = i + 1;
      if (err_mem[a[12:0]]) begin
        r.stat = 3'd3;
        return r;
      end
      b[i] = mem[a[12:0]];
      if (i == 0) begin
        len = len_of_icode(b[0][7:4]);
        if (len == 0) begin
          r.stat = 3'd4;
          return r;
        end
      end
    end
    r.icode = b[0][7:4];
    r.ifun  = b[0][3:0];
    if (len == 2 || len == 10) begin
      r.ra = b[1][7:4];
      r.rb = b[1][3:0];
    end
    if (len >= 9)
      for (int j = 0; j < 8; j++) r.valc = r.valc | (64'(b[len - 8 + j]) << (8 * j));
    r.valp = start + 64'(len);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_fetch(input logic [63:0] start, input int w, input string tag, output ref_t r);
    int cyc;
    int lat;
    r = model(start, 64'hFFF);
    @(negedge clk);
    pc_load = 1'b1; pc_in = start; mem_wait = w;
    @(negedge clk);
    pc_load = 1'b0; en = 1'b1;
    exp_q.delete();
    for (int i = 0; i < r.nbytes; i++) exp_q.push_back(start + 64'(i));
    sb_on = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (!out_valid && stat == 3'd1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    lat = r.nbytes * (w + 1) + (r.addr_fault ? 1 : 0);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_stat"}, stat, r.stat);
    check({tag, "_valid"}, out_valid, (r.stat == 3'd1));
    check({tag, "_pc"}, pc, start);
    if (r.stat == 3'd1) begin
      check({tag, "_icode"}, icode, r.icode);
      check({tag, "_ifun"}, ifun, r.ifun);
      check({tag, "_ra"}, ra, r.ra);
      check({tag, "_rb"}, rb, r.rb);
      check({tag, "_valc"}, valc, r.valc);
      check({tag, "_valp"}, valp, r.valp);
    end
    check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;
  endtask

  task automatic retire(input int d, input logic [2:0] exp_stat, input logic [63:0] exp_valc);
    repeat (d) @(negedge clk);
    check("hold_valid", out_valid, 1'b1);
    check("hold_valc", valc, exp_valc);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_valid", out_valid, 1'b0);
    check("retire_stat", stat, exp_stat);
  endtask

  task automatic expect_quiet(input int n, input string tag);
    int base;
    @(negedge clk); #1;
    base = req_seen;
    repeat (n) @(negedge clk);
    #1;
    check(tag, 64'(req_seen - base), 64'd0);
  endtask

  task automatic put_bytes(input logic [63:0] a, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [63:0] c);
    mem[a[12:0]]         = b0;
    mem[13'(a[12:0] + 1)] = b1;
    for (int i = 0; i < 8; i++) mem[13'(a[12:0] + 13'(i + 2))] = c[8*i +: 8];
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    ref_t r;
    int   base;
    int   cyc;
    logic [63:0] start;
    logic [63:0] eaddr;
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'h00;
      err_mem[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("rst_pc", pc, 64'h0);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_stat", stat, 3'd1);
    check("rst_icode", icode, 4'h0);
    check("rst_ifun", ifun, 4'h0);
    check("rst_ra", ra, 4'hF);
    check("rst_rb", rb, 4'hF);
    check("rst_valc", valc, 64'd0);
    check("rst_valp", valp, 64'd0);
    rst_n = 1'b1;

    // irmovq at 0x5 with only 0x0..0x9 legal
    put_bytes(64'h5, 8'h30, 8'hF3, 64'h0A);
    @(negedge clk);
    s_pc_load = 1'b1; s_pc_in = 64'h5;
    @(negedge clk);
    s_pc_load = 1'b0; s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    cyc = 0;
    while (s_stat == 3'd1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("small_stat", s_stat, 3'd3);
    check("small_latency", 64'(cyc), 64'd6);
    check("small_max_addr", s_max_seen, 64'h9);
    check("small_valid", s_valid, 1'b0);

    // irmovq $10, %rbx at 0 with zero-wait memory
    put_bytes(64'h0, 8'h30, 8'hF3, 64'h0A);
    run_fetch(64'h0, 0, "irmovq", r);
    check("irmovq_valc_const", valc, 64'd10);
    check("irmovq_rb_const", rb, 4'h3);
    retire(1, 3'd1, 64'd10);

    // ret with a 2-cycle ack
    mem[12'h20] = 8'h90;
    run_fetch(64'h20, 2, "ret", r);
    check("ret_valp_const", valp, 64'h21);
    retire(0, 3'd1, 64'd0);

    // jmp 0x100, then PC update loads the target
    mem[12'h40] = 8'h70;
    mem[12'h41] = 8'h00; mem[12'h42] = 8'h01;
    for (int i = 3; i < 9; i++) mem[12'h40 + i] = 8'h00;
    mem[12'h100] = 8'h10;
    run_fetch(64'h40, 0, "jmp", r);
    check("jmp_valc_const", valc, 64'h100);
    retire(2, 3'd1, 64'h100);
    expect_quiet(4, "jmp_wait_quiet");
    run_fetch(64'h100, 1, "jmp_target", r);
    retire(0, 3'd1, 64'd0);

    // invalid instruction byte
    mem[0] = 8'hC0;
    run_fetch(64'h0, 1, "ins", r);
    expect_quiet(10, "ins_quiet");
    run_fetch(64'h0, 0, "ins_refetch", r);

    // halt stops the stage
    mem[12'h60] = 8'h00;
    run_fetch(64'h60, 0, "halt", r);
    retire(0, 3'd2, 64'd0);
    expect_quiet(20, "halt_quiet");
    check("halt_pc", pc, 64'h60);

    // pc_load beats a DONE handshake on the same edge
    mem[12'h70] = 8'h00;
    run_fetch(64'h70, 0, "prio", r);
    pc_load = 1'b1; pc_in = 64'h300; out_ready = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; out_ready = 1'b0;
    check("prio_valid", out_valid, 1'b0);
    check("prio_stat", stat, 3'd1);
    check("prio_pc", pc, 64'h300);
    expect_quiet(5, "prio_idle_quiet");

    // reset pulsed in the middle of an irmovq fetch
    put_bytes(64'h90, 8'h30, 8'hF2, 64'h1234);
    @(negedge clk);
    pc_load = 1'b1; pc_in = 64'h90; mem_wait = 0;
    @(negedge clk);
    pc_load = 1'b0; en = 1'b1; base = ack_cnt;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while ((ack_cnt - base) < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_progress", 64'(ack_cnt - base >= 3), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", imem_req, 1'b0);
    check("rst_mid_pc", pc, 64'h0);
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_stat", stat, 3'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // rmmovq aborted by pc_load while byte 4 is being acked
    put_bytes(64'hA0, 8'h40, 8'h12, 64'h55AA);
    mem[12'h80] = 8'h10;
    @(negedge clk);
    pc_load = 1'b1; pc_in = 64'hA0; mem_wait = 0;
    @(negedge clk);
    pc_load = 1'b0; en = 1'b1; base = ack_cnt;
    @(negedge clk);
    en = 1'b0;
    #1;
    cyc = 0;
    while ((ack_cnt - base) < 5 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("abort_progress", 64'(ack_cnt - base), 64'd5);
    pc_load = 1'b1; pc_in = 64'h80;
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    check("abort_req", imem_req, 1'b0);
    check("abort_pc", pc, 64'h80);
    check("abort_valid", out_valid, 1'b0);
    run_fetch(64'h80, 0, "after_abort", r);
    retire(1, 3'd1, 64'd0);

    // randomized fetches
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0:       start = 64'hFF8 + 64'($urandom_range(0, 7));
        1:       start = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: start = 64'h200 + 64'($urandom_range(0, 12'hD00));
      endcase
      if (start <= 64'hFFF) begin
        for (int i = 0; i < 10; i++) begin
          eaddr = start + 64'(i);
          mem[eaddr[12:0]]     = 8'($urandom_range(0, 255));
          err_mem[eaddr[12:0]] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          eaddr = start + 64'($urandom_range(0, 9));
          err_mem[eaddr[12:0]] = 1'b1;
        end
      end
      run_fetch(start, $urandom_range(0, 2), "rand", r);
      if (r.stat == 3'd1)
        retire($urandom_range(0, 3), (r.icode == 4'h0) ? 3'd2 : 3'd1, r.valc);
      expect_quiet(3, "rand_quiet");
      if (start <= 64'hFFF)
        for (int i = 0; i < 10; i++) begin
          eaddr = start + 64'(i);
          err_mem[eaddr[12:0]] = 1'b0;
        end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
